// File: rtl/alarm_controller.sv
// Alarm scheduler beside the HH:MM:SS BCD counters: stores an alarm time edited with the
// three-button scheme, rings on a rising time match, and handles snooze, dismiss and arm.
module alarm_controller #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SecondTick,
    input  logic [3:0] HourMSD,
    input  logic [3:0] HourLSD,
    input  logic [3:0] MinMSD,
    input  logic [3:0] MinLSD,
    input  logic [3:0] SecMSD,
    input  logic [3:0] SecLSD,
    input  logic       ButtonSet,
    input  logic       ButtonDigit,
    input  logic       ButtonValue,
    input  logic       ButtonSnooze,
    input  logic       ButtonArm,
    output logic       Armed,
    output logic       Ringing,
    output logic       Setting,
    output logic       ActiveField,
    output logic [3:0] AlarmHourMSD,
    output logic [3:0] AlarmHourLSD,
    output logic [3:0] AlarmMinMSD,
    output logic [3:0] AlarmMinLSD
);
    // state     | meaning
    // ST_IDLE   | watching the alarm time, arm toggle allowed
    // ST_SET    | editing alarm hours/minutes, no triggers
    // ST_RING   | ring active, counting seconds until timeout
    // ST_SNOOZE | watching the snooze target
    typedef enum logic [1:0] {ST_IDLE, ST_SET, ST_RING, ST_SNOOZE} state_t;

    localparam logic [4:0] SNZ_ADD = 5'(SNOOZE_MINUTES);
    localparam logic [7:0] RING_TC = 8'(RING_SECONDS);

    state_t     state_q;
    logic       armed_q, ringing_q, setting_q, field_q, match_q;
    logic [7:0] al_hr_q, al_min_q, sz_hr_q, sz_min_q;
    logic [7:0] ring_cnt_q;
    logic [7:0] sz_hr_d, sz_min_d;
    logic [4:0] min_sum;
    logic [3:0] lsd_wrap;
    logic       sec_zero, match_alarm, match_snooze, match_cur, trigger;

    function automatic logic [7:0] hour_inc(input logic [7:0] h);
        if (h == 8'h23)
            return 8'h00;
        else if (h[3:0] == 4'd9)
            return {h[7:4] + 4'd1, 4'd0};
        else
            return {h[7:4], h[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] min_inc(input logic [7:0] m);
        if (m[3:0] != 4'd9)
            return {m[7:4], m[3:0] + 4'd1};
        else if (m[7:4] == 4'd5)
            return 8'h00;
        else
            return {m[7:4] + 4'd1, 4'd0};
    endfunction

    assign sec_zero     = (SecMSD == 4'd0) && (SecLSD == 4'd0);
    assign match_alarm  = sec_zero && ({HourMSD, HourLSD, MinMSD, MinLSD} == {al_hr_q, al_min_q});
    assign match_snooze = sec_zero && ({HourMSD, HourLSD, MinMSD, MinLSD} == {sz_hr_q, sz_min_q});
    assign match_cur    = (state_q == ST_SNOOZE) ? match_snooze : match_alarm;
    assign trigger      = armed_q && match_cur && !match_q;

    // Snooze target: current HH:MM plus SNOOZE_MINUTES, BCD with carry into hours
    always_comb begin
        min_sum  = {1'b0, MinLSD} + SNZ_ADD;
        lsd_wrap = min_sum[3:0] - 4'd10;
        sz_hr_d  = {HourMSD, HourLSD};
        sz_min_d = {MinMSD, min_sum[3:0]};
        if (min_sum >= 5'd10) begin
            if (MinMSD == 4'd5) begin
                sz_min_d = {4'd0, lsd_wrap};
                sz_hr_d  = hour_inc({HourMSD, HourLSD});
            end else begin
                sz_min_d = {MinMSD + 4'd1, lsd_wrap};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b0;
            ringing_q  <= 1'b0;
            setting_q  <= 1'b0;
            field_q    <= 1'b0;
            match_q    <= 1'b0;
            al_hr_q    <= 8'h00;
            al_min_q   <= 8'h00;
            sz_hr_q    <= 8'h00;
            sz_min_q   <= 8'h00;
            ring_cnt_q <= 8'd0;
        end else begin
            // History follows the target in force; state entries below override it
            match_q <= match_cur;
            case (state_q)
                ST_IDLE: begin
                    if (ButtonSet) begin
                        state_q   <= ST_SET;
                        setting_q <= 1'b1;
                        field_q   <= 1'b0;
                    end else if (trigger) begin
                        state_q    <= ST_RING;
                        ringing_q  <= 1'b1;
                        ring_cnt_q <= 8'd0;
                    end else if (ButtonArm) begin
                        armed_q <= ~armed_q;
                    end
                end
                ST_SET: begin
                    if (ButtonSet) begin
                        state_q   <= ST_IDLE;
                        setting_q <= 1'b0;
                    end else if (ButtonDigit) begin
                        field_q <= ~field_q;
                    end else if (ButtonValue) begin
                        if (field_q)
                            al_min_q <= min_inc(al_min_q);
                        else
                            al_hr_q <= hour_inc(al_hr_q);
                    end
                end
                ST_RING: begin
                    if (ButtonArm) begin
                        state_q   <= ST_IDLE;
                        ringing_q <= 1'b0;
                    end else if (ButtonSnooze) begin
                        state_q   <= ST_SNOOZE;
                        ringing_q <= 1'b0;
                        sz_hr_q   <= sz_hr_d;
                        sz_min_q  <= sz_min_d;
                        match_q   <= 1'b0;
                    end else if (SecondTick) begin
                        if (ring_cnt_q == RING_TC - 8'd1) begin
                            state_q   <= ST_IDLE;
                            ringing_q <= 1'b0;
                        end else begin
                            ring_cnt_q <= ring_cnt_q + 8'd1;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (ButtonArm) begin
                        state_q <= ST_IDLE;
                        match_q <= match_alarm;
                    end else if (trigger) begin
                        state_q    <= ST_RING;
                        ringing_q  <= 1'b1;
                        ring_cnt_q <= 8'd0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Armed        = armed_q;
    assign Ringing      = ringing_q;
    assign Setting      = setting_q;
    assign ActiveField  = field_q;
    assign AlarmHourMSD = al_hr_q[7:4];
    assign AlarmHourLSD = al_hr_q[3:0];
    assign AlarmMinMSD  = al_min_q[7:4];
    assign AlarmMinLSD  = al_min_q[3:0];
endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: a time-of-day reference model in plain integers
// predicts every cycle's outputs; a monitor pops and compares them after each clock edge.
module tb_alarm_controller;
    localparam int RING_S = 60;
    localparam int SNZ_M  = 5;
    localparam logic [4:0] B_SET = 5'b10000, B_DIG = 5'b01000, B_VAL = 5'b00100,
                           B_SNZ = 5'b00010, B_ARM = 5'b00001, B_NONE = 5'b00000;
    localparam int M_IDLE = 0, M_SET = 1, M_RING = 2, M_SNOOZE = 3;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST, SecondTick;
    logic [3:0] HourMSD, HourLSD, MinMSD, MinLSD, SecMSD, SecLSD;
    logic       ButtonSet, ButtonDigit, ButtonValue, ButtonSnooze, ButtonArm;
    logic       Armed, Ringing, Setting, ActiveField;
    logic [3:0] AlarmHourMSD, AlarmHourLSD, AlarmMinMSD, AlarmMinLSD;

    alarm_controller #(.RING_SECONDS(RING_S), .SNOOZE_MINUTES(SNZ_M)) dut (
        .CLK(CLK), .RST(RST), .SecondTick(SecondTick),
        .HourMSD(HourMSD), .HourLSD(HourLSD), .MinMSD(MinMSD), .MinLSD(MinLSD),
        .SecMSD(SecMSD), .SecLSD(SecLSD),
        .ButtonSet(ButtonSet), .ButtonDigit(ButtonDigit), .ButtonValue(ButtonValue),
        .ButtonSnooze(ButtonSnooze), .ButtonArm(ButtonArm),
        .Armed(Armed), .Ringing(Ringing), .Setting(Setting), .ActiveField(ActiveField),
        .AlarmHourMSD(AlarmHourMSD), .AlarmHourLSD(AlarmHourLSD),
        .AlarmMinMSD(AlarmMinMSD), .AlarmMinLSD(AlarmMinLSD)
    );

    typedef struct packed {
        logic        armed;
        logic        ringing;
        logic        setting;
        logic        field;
        logic [15:0] alarm;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: times as seconds/minutes of day
    int tod = 0;
    int m_mode = M_IDLE, m_alarm = 0, m_snz = 0, m_cnt = 0;
    bit m_armed = 0, m_field = 0, m_prev = 0;

    function automatic int hms(input int h, input int m, input int s);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [15:0] bcd_hm(input int mins);
        int h, m;
        h = mins / 60;
        m = mins % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic model_edge(input bit rst_n, input bit tick, input logic [4:0] b);
        int  cur_min, sec, target;
        bit  match, rise;
        if (!rst_n) begin
            m_mode = M_IDLE; m_armed = 0; m_field = 0; m_alarm = 0;
            m_snz = 0; m_cnt = 0; m_prev = 0;
            return;
        end
        cur_min = tod / 60;
        sec     = tod % 60;
        target  = (m_mode == M_SNOOZE) ? m_snz : m_alarm;
        match   = (cur_min == target) && (sec == 0);
        rise    = match && !m_prev;
        case (m_mode)
            M_IDLE:
                if (b[4]) begin m_mode = M_SET; m_field = 0; end
                else if (m_armed && rise) begin m_mode = M_RING; m_cnt = 0; end
                else if (b[0]) m_armed = !m_armed;
            M_SET:
                if (b[4]) m_mode = M_IDLE;
                else if (b[3]) m_field = !m_field;
                else if (b[2]) begin
                    if (!m_field) m_alarm = ((m_alarm / 60 + 1) % 24) * 60 + m_alarm % 60;
                    else          m_alarm = (m_alarm / 60) * 60 + (m_alarm % 60 + 1) % 60;
                end
            M_RING:
                if (b[0]) m_mode = M_IDLE;
                else if (b[1]) begin m_snz = (cur_min + SNZ_M) % 1440; m_mode = M_SNOOZE; end
                else if (tick) begin
                    m_cnt++;
                    if (m_cnt == RING_S) m_mode = M_IDLE;
                end
            default:
                if (b[0]) m_mode = M_IDLE;
                else if (m_armed && rise) begin m_mode = M_RING; m_cnt = 0; end
        endcase
        // history is the match against whichever target is now in force
        target = (m_mode == M_SNOOZE) ? m_snz : m_alarm;
        m_prev = (cur_min == target) && (sec == 0);
    endtask

    task automatic drive_time();
        int h, m, s;
        h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
        HourMSD = 4'(h / 10); HourLSD = 4'(h % 10);
        MinMSD  = 4'(m / 10); MinLSD  = 4'(m % 10);
        SecMSD  = 4'(s / 10); SecLSD  = 4'(s % 10);
    endtask

    task automatic step(input bit rst_n, input bit tick, input logic [4:0] b);
        exp_t e;
        @(negedge CLK);
        RST = rst_n; SecondTick = tick;
        {ButtonSet, ButtonDigit, ButtonValue, ButtonSnooze, ButtonArm} = b;
        drive_time();
        model_edge(rst_n, tick, b);
        e.armed   = m_armed;
        e.ringing = (m_mode == M_RING);
        e.setting = (m_mode == M_SET);
        e.field   = m_field;
        e.alarm   = bcd_hm(m_alarm);
        exp_q.push_back(e);
    endtask

    task automatic tick_adv();
        tod = (tod + 1) % 86400;
        step(1, 1, B_NONE);
    endtask

    task automatic tick_hold();
        step(1, 1, B_NONE);
    endtask

    task automatic settle();
        @(posedge CLK);
        #3;
    endtask

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: one expected record per applied edge
    initial begin
        exp_t e, act;
        forever begin
            @(posedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {Armed, Ringing, Setting, ActiveField,
                       AlarmHourMSD, AlarmHourLSD, AlarmMinMSD, AlarmMinLSD};
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    if (miscompares <= 20)
                        $display("FAIL outputs t=%0t got arm=%b ring=%b set=%b fld=%b alarm=%h want arm=%b ring=%b set=%b fld=%b alarm=%h",
                                 $time, act.armed, act.ringing, act.setting, act.field, act.alarm,
                                 e.armed, e.ringing, e.setting, e.field, e.alarm);
                end
            end
        end
    end

    initial begin
        int r, tgt;
        bit tk, rn;
        logic [4:0] b;
        RST = 0; SecondTick = 0;
        {ButtonSet, ButtonDigit, ButtonValue, ButtonSnooze, ButtonArm} = B_NONE;
        drive_time();

        step(0, 0, B_NONE); step(0, 0, B_NONE); step(1, 0, B_NONE); settle();
        chk("rst_armed", Armed, 0);
        chk("rst_alarm", {AlarmHourMSD, AlarmHourLSD, AlarmMinMSD, AlarmMinLSD}, 'h0000);
        chk("rst_ringing", Ringing, 0);

        step(1, 0, B_ARM); settle(); chk("arm_toggle1", Armed, 1);
        step(1, 0, B_ARM); settle(); chk("arm_toggle2", Armed, 0);
        step(1, 0, B_ARM); settle(); chk("arm_toggle3", Armed, 1);

        step(1, 0, B_SET); settle(); chk("set_entry", {Setting, ActiveField}, 2);
        repeat (7) step(1, 0, B_VAL);
        step(1, 0, B_DIG);
        repeat (30) step(1, 0, B_VAL);
        step(1, 0, B_SET); settle();
        chk("alarm_0730", {AlarmHourMSD, AlarmHourLSD, AlarmMinMSD, AlarmMinLSD}, 'h0730);
        chk("set_exit", Setting, 0);
        step(1, 0, B_SET); repeat (17) step(1, 0, B_VAL); step(1, 0, B_SET); settle();
        chk("hour_wrap", {AlarmHourMSD, AlarmHourLSD, AlarmMinMSD, AlarmMinLSD}, 'h0030);
        step(1, 0, B_SET); repeat (7) step(1, 0, B_VAL); step(1, 0, B_SET);

        tod = hms(7, 29, 58); step(1, 0, B_NONE);
        tick_adv(); tick_adv(); settle();
        chk("ring_start", Ringing, 1);
        repeat (RING_S - 1) tick_hold();
        settle(); chk("ring_before_timeout", Ringing, 1);
        tick_hold(); settle(); chk("ring_timeout", Ringing, 0);
        repeat (10) tick_hold();
        settle(); chk("no_retrigger", Ringing, 0);

        step(1, 0, B_SET); repeat (16) step(1, 0, B_VAL);
        step(1, 0, B_DIG); repeat (27) step(1, 0, B_VAL); step(1, 0, B_SET); settle();
        chk("alarm_2357", {AlarmHourMSD, AlarmHourLSD, AlarmMinMSD, AlarmMinLSD}, 'h2357);
        tod = hms(23, 56, 59); step(1, 0, B_NONE); tick_adv(); settle();
        chk("ring_2357", Ringing, 1);
        step(1, 0, B_SNZ); settle(); chk("snooze_stop", Ringing, 0);
        tod = hms(0, 1, 58); step(1, 0, B_NONE); tick_adv(); settle();
        chk("snooze_wait", Ringing, 0);
        tick_adv(); settle(); chk("snooze_fire", Ringing, 1);

        step(1, 0, B_ARM | B_SNZ); settle();
        chk("dismiss_wins_ring", Ringing, 0);
        chk("dismiss_keeps_arm", Armed, 1);
        tod = hms(0, 6, 59); step(1, 0, B_NONE); tick_adv(); settle();
        chk("no_snooze_after_dismiss", Ringing, 0);

        tod = hms(23, 56, 59); step(1, 0, B_NONE); tick_adv(); settle();
        chk("ring_again", Ringing, 1);
        step(0, 0, B_NONE); settle();
        chk("midring_rst_ring", Ringing, 0);
        chk("midring_rst_arm", Armed, 0);
        chk("midring_rst_alarm", {AlarmHourMSD, AlarmHourLSD, AlarmMinMSD, AlarmMinLSD}, 'h0000);
        step(1, 0, B_NONE);
        tod = hms(23, 59, 58); step(1, 0, B_NONE);
        tick_adv(); tick_adv(); repeat (5) tick_hold(); settle();
        chk("disarmed_no_ring", Ringing, 0);

        // Randomized phase: ticks, time jumps near the live target, single button pulses
        for (int i = 0; i < 16000; i++) begin
            r  = $urandom_range(0, 99);
            tk = 0; b = B_NONE; rn = 1;
            if (r < 30) begin
                tod = (tod + 1) % 86400;
                tk  = 1;
            end else if (r < 32) begin
                tgt = (m_mode == M_SNOOZE) ? m_snz : m_alarm;
                tod = (tgt * 60 - int'($urandom_range(1, 4)) + 86400) % 86400;
            end else if (r < 41) begin
                case ($urandom_range(0, 4))
                    0: b = B_SET;
                    1: b = B_DIG;
                    2: b = B_VAL;
                    3: b = B_SNZ;
                    default: b = B_ARM;
                endcase
            end
            if ($urandom_range(0, 2999) == 0) rn = 0;
            step(rn, tk, b);
        end

        settle();
        repeat (3) @(posedge CLK);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
